// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words and
// writes them to consecutive word addresses of an instruction memory.
module instr_mem_loader #(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  state_dbg
);
    localparam int IW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    byte_cnt;
    logic [IW-1:0] word_idx;
    logic [31:0]   word;
    logic          last_seen;
    logic          err_q;
    logic          hs;
    logic          full;

    // Handshake: a byte transfers on a posedge where byte_valid && byte_ready;
    // byte_ready depends only on state, never on byte_valid.
    assign hs   = byte_valid && byte_ready;
    assign full = (word_idx == IW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                if (hs) begin
                    if (full) begin
                        state_nx = DONE;
                    end else if (byte_last || byte_cnt == 2'd3) begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                state_nx = last_seen ? DONE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The first byte of a word clears the rest, so a short final word is zero-filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= 2'd0;
            word_idx  <= '0;
            word      <= 32'h0;
            last_seen <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_cnt  <= 2'd0;
                        word_idx  <= '0;
                        last_seen <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        if (full) begin
                            err_q <= 1'b1;
                        end else begin
                            case (byte_cnt)
                                2'd0:    word        <= {byte_in, 24'h0};
                                2'd1:    word[23:16] <= byte_in;
                                2'd2:    word[15:8]  <= byte_in;
                                default: word[7:0]   <= byte_in;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_last) begin
                                last_seen <= 1'b1;
                                if (byte_cnt != 2'd3) err_q <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + IW'(1);
                    byte_cnt <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_ready = (state == LOAD);
        wr_en      = (state == WRITE);
        busy       = (state == LOAD) || (state == WRITE);
        done       = (state == DONE);
    end

    assign wr_addr   = {{(30 - IW){1'b0}}, word_idx, 2'b00};
    assign wr_data   = word;
    assign err       = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 512-word and a 2-word instance share one driver,
// writes are scored against a queue filled by a byte-packing model.
module tb_instr_mem_loader;
    logic clk;
    logic rst;
    logic sel;
    logic start;
    logic [7:0] byte_in;
    logic byte_valid;
    logic byte_last;

    logic a_ready, a_wr_en, a_busy, a_done, a_err;
    logic [31:0] a_wr_addr, a_wr_data;
    logic [1:0] a_st;
    logic b_ready, b_wr_en, b_busy, b_done, b_err;
    logic [31:0] b_wr_addr, b_wr_data;
    logic [1:0] b_st;

    logic ready, wr_en, busy, done, err;
    logic [31:0] wr_addr, wr_data;
    logic [1:0] st;

    int checks;
    int errors;
    int cycle;
    int wr_cnt;
    logic [31:0] last_data;
    int wr_cycles[$];
    logic [63:0] exp_q[$];

    int m_cnt;
    int m_words;
    int m_depth;
    logic [31:0] m_w;

    instr_mem_loader #(.DEPTH(512)) dut_a (
        .clk(clk), .rst(rst), .start(start && !sel), .byte_in(byte_in),
        .byte_valid(byte_valid && !sel), .byte_last(byte_last), .byte_ready(a_ready),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .err(a_err), .state_dbg(a_st)
    );

    instr_mem_loader #(.DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(start && sel), .byte_in(byte_in),
        .byte_valid(byte_valid && sel), .byte_last(byte_last), .byte_ready(b_ready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .err(b_err), .state_dbg(b_st)
    );

    assign ready   = sel ? b_ready   : a_ready;
    assign wr_en   = sel ? b_wr_en   : a_wr_en;
    assign wr_addr = sel ? b_wr_addr : a_wr_addr;
    assign wr_data = sel ? b_wr_data : a_wr_data;
    assign busy    = sel ? b_busy    : a_busy;
    assign done    = sel ? b_done    : a_done;
    assign err     = sel ? b_err     : a_err;
    assign st      = sel ? b_st      : a_st;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Scoreboard side: every write strobe pops one expected {addr, data}.
    always @(negedge clk) begin
        if (wr_en) begin
            logic [63:0] e;
            wr_cnt++;
            last_data = wr_data;
            wr_cycles.push_back(cycle);
            check("ready_low_in_write", ready, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e[63:32]);
                check("wr_data", wr_data, e[31:0]);
            end
        end
    end

    // Reference packing model, fed once per accepted byte.
    task automatic model_byte(input logic [7:0] b, input logic last);
        if (m_words == m_depth) return;
        if (m_cnt == 0) m_w = {b, 24'h0};
        else m_w[31 - 8 * m_cnt -: 8] = b;
        if (last || m_cnt == 3) begin
            exp_q.push_back({32'(m_words * 4), m_w});
            m_words++;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Driver tasks
    task automatic start_session();
        m_cnt = 0;
        m_words = 0;
        m_w = 32'h0;
        m_depth = sel ? 2 : 512;
        wr_cnt = 0;
        wr_cycles.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic stream(input int n, input logic [127:0] bytes, input int last_idx);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 200) begin
            byte_in = bytes[127 - 8 * i -: 8];
            byte_last = (i == last_idx);
            byte_valid = 1'b1;
            @(negedge clk);
            if (ready) begin
                model_byte(byte_in, byte_last);
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        byte_valid = 1'b0;
        byte_last = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout accepted=%0d required=%0d", i, n);
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("done_reached", done, 1'b1);
    endtask

    typedef struct {
        logic         sel;
        int           n;
        logic [127:0] bytes;
        int           last_idx;
        logic         exp_err;
        int           exp_writes;
        logic [31:0]  exp_last;
        logic         gap5;
    } vec_t;

    vec_t vecs[7];

    initial begin
        checks = 0;
        errors = 0;
        cycle = 0;
        wr_cnt = 0;
        sel = 1'b0;
        start = 1'b0;
        byte_in = 8'h0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        rst = 1'b1;

        vecs[0] = '{1'b0, 4,  {32'h20080005, 96'h0}, 3, 1'b0, 1, 32'h20080005, 1'b0};
        vecs[1] = '{1'b0, 12, 128'h00112233_44556677_8899AABB_00000000, 11, 1'b0, 3, 32'h8899AABB, 1'b1};
        vecs[2] = '{1'b0, 6,  {48'hAAABACADAEAF, 80'h0}, 5, 1'b1, 2, 32'hAEAF0000, 1'b0};
        vecs[3] = '{1'b0, 1,  {8'h7F, 120'h0}, 0, 1'b1, 1, 32'h7F000000, 1'b0};
        vecs[4] = '{1'b0, 8,  {64'h01020304_05060708, 64'h0}, 7, 1'b0, 2, 32'h05060708, 1'b1};
        vecs[5] = '{1'b0, 7,  {56'hDEADBEEFCAFE12, 72'h0}, 6, 1'b1, 2, 32'hCAFE1200, 1'b0};
        vecs[6] = '{1'b1, 9,  {72'h10111213_14151617_18, 56'h0}, -1, 1'b1, 2, 32'h14151617, 1'b1};

        #12;
        check("rst_ready", ready, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 32'h0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_busy_done_err", {busy, done, err}, 3'b000);
        check("rst_state", st, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            sel = vecs[k].sel;
            start_session();
            stream(vecs[k].n, vecs[k].bytes, vecs[k].last_idx);
            wait_done();
            check($sformatf("v%0d_err", k), err, vecs[k].exp_err);
            check($sformatf("v%0d_busy", k), busy, 1'b0);
            check($sformatf("v%0d_writes", k), wr_cnt, vecs[k].exp_writes);
            check($sformatf("v%0d_last_data", k), last_data, vecs[k].exp_last);
            check($sformatf("v%0d_queue_left", k), exp_q.size(), 0);
            if (vecs[k].gap5) begin
                for (int j = 1; j < wr_cycles.size(); j++) begin
                    check($sformatf("v%0d_wr_gap", k), wr_cycles[j] - wr_cycles[j-1], 5);
                end
            end
        end

        // Reset in the middle of the second word.
        sel = 1'b0;
        start_session();
        stream(6, {48'h0A0B0C0D_0E0F, 80'h0}, -1);
        rst = 1'b1;
        #2;
        check("midrst_ready", ready, 1'b0);
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_wr_addr", wr_addr, 32'h0);
        check("midrst_wr_data", wr_data, 32'h0);
        check("midrst_busy_done_err", {busy, done, err}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_writes", wr_cnt, 1);
        check("midrst_queue_left", exp_q.size(), 0);
        @(posedge clk); #1;
        start_session();
        stream(4, {32'hC0DEF00D, 96'h0}, 3);
        wait_done();
        check("after_rst_writes", wr_cnt, 1);
        check("after_rst_data", last_data, 32'hC0DEF00D);
        check("after_rst_err", err, 1'b0);

        // start during LOAD is ignored; word index keeps counting.
        start_session();
        stream(4, {32'h11223344, 96'h0}, -1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_load_busy", busy, 1'b1);
        stream(4, {32'h55667788, 96'h0}, 3);
        wait_done();
        check("start_in_load_writes", wr_cnt, 2);
        check("start_in_load_err", err, 1'b0);

        // start in DONE clears done and err, and restarts at address 0.
        start_session();
        stream(1, {8'hAB, 120'h0}, 0);
        wait_done();
        check("short_err", err, 1'b1);
        start_session();
        check("restart_done", done, 1'b0);
        check("restart_err", err, 1'b0);
        check("restart_busy", busy, 1'b1);
        stream(4, {32'hFEEDFACE, 96'h0}, 3);
        wait_done();
        check("restart_writes", wr_cnt, 1);
        check("restart_queue_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning the number of 32-bit instruction-memory words writable.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin a load session.
REQ-005 SHALL have port byte_in, input, 8 bits: program byte.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_in valid.
REQ-007 SHALL have port byte_last, input, 1 bit: qualifies the final byte of the program.
REQ-008 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port wr_en, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port wr_addr, output, 32 bits: byte address of the written word, always word-aligned.
REQ-011 SHALL have port wr_data, output, 32 bits: assembled instruction word.
REQ-012 SHALL have ports busy, done, err, outputs, 1 bit each: session active, session complete, session error.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-014 SHALL accept a byte only on a cycle where byte_valid=1 and byte_ready=1 (handshake).
REQ-015 SHALL drive byte_ready=1 only in LOAD.
REQ-016 SHALL move IDLE->LOAD on start=1, clearing the byte counter (0..3), the word index, done, and err.
REQ-017 SHALL pack bytes big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-018 SHALL move LOAD->WRITE on the cycle after the 4th byte handshake, or after a byte_last handshake at any byte count.
REQ-019 SHALL, for a byte_last word with fewer than 4 bytes, zero-fill the unreceived low bytes and set err=1.
REQ-020 SHALL assert wr_en for exactly one cycle in WRITE, with wr_addr = word index * 4 and wr_data = assembled word.
REQ-021 SHALL increment the word index after each write; WRITE->LOAD normally; WRITE->DONE when the word carried byte_last.
REQ-022 SHALL, if a byte handshake occurs in LOAD while the word index equals DEPTH, discard the byte, set err=1, and go to DONE without writing.
REQ-023 SHALL hold wr_en=0 outside WRITE; wr_addr/wr_data SHALL be don't-care when wr_en=0.
REQ-024 SHALL drive busy=1 in LOAD and WRITE, else 0.
REQ-025 SHALL hold done=1 and err sticky in DONE until the next start.
REQ-026 SHALL move DONE->LOAD on start=1 (new session, counters and flags cleared); start SHALL be ignored in LOAD and WRITE.
REQ-027 SHALL sustain a throughput of 4 bytes per 5 cycles with byte_valid held high.
REQ-028 SHALL accept byte_last=1 together with any byte-count position, including the 4th byte (no padding, err unchanged).

Reset
REQ-029 SHALL, on rst=1 at any time including mid-session, immediately enter IDLE and drive byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, with counters cleared.
REQ-030 SHALL issue no write for a partially assembled word interrupted by reset.

Verification
REQ-031 Bench SHALL check: start, bytes 8'h20,8'h08,8'h00,8'h05 (last on 4th) -> one wr_en, wr_addr=0, wr_data=32'h20080005, then done=1, err=0.
REQ-032 Bench SHALL check: 12 bytes streamed with byte_valid held high -> writes at wr_addr 0,4,8, wr_en spaced 5 cycles apart, byte_ready low each WRITE cycle.
REQ-033 Bench SHALL check: 6 bytes 8'hAA..8'hAF, last on 6th -> 2nd write wr_addr=4, wr_data=32'hAEAF0000, err=1, done=1.
REQ-034 Bench SHALL check: DEPTH=2, 9 bytes offered -> two writes (addr 0, 4), 9th byte dropped, no third wr_en, err=1, done=1.
REQ-035 Bench SHALL check: rst pulsed after 2 bytes of the second word -> all outputs 0, no write; a fresh start then writes the first word at wr_addr=0.
REQ-036 Bench SHALL check: start asserted during LOAD -> ignored, word index continues; start in DONE -> done and err clear, next write at wr_addr=0.
